// File: rtl/elevator_pkg.sv
// Shared types and default timing constants for the elevator door timer and the FSM bench.
package elevator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } door_timer_state_e;

   localparam int unsigned DEF_PRESCALE         = 4;
   localparam int unsigned DEF_DURATION_W       = 8;
   localparam int unsigned DEF_DURATION_TICKS   = 10;

endpackage

// File: rtl/elevator_tick_prescaler.sv
// Free-running 0..PRESCALE-1 counter that emits a one-cycle tick on its last count.
module elevator_tick_prescaler
   import elevator_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clear_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_comb tick_o = (cnt_q == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/elevator_door_timer.sv
// Door-open timer fed by the elevator control FSM; counts door periods in prescaled ticks.
// Define ELEVATOR_DOOR_TIMER_OBSTRUCT_EN to let obstruct_i restart a running period.
module elevator_door_timer
   import elevator_pkg::*;
#(
   parameter int unsigned PRESCALE         = DEF_PRESCALE,
   parameter int unsigned DURATION_W       = DEF_DURATION_W,
   parameter int unsigned DEFAULT_DURATION = DEF_DURATION_TICKS
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  counter_init_i,
   input  logic [DURATION_W-1:0] duration_i,
   input  logic                  obstruct_i,
   output logic                  counter_done_o,
   output logic                  busy_o,
   output logic [DURATION_W-1:0] remaining_o
);

   door_timer_state_e     state_q, state_d;
   logic [DURATION_W-1:0] remaining_q, remaining_d;
   logic [DURATION_W-1:0] stored_q, stored_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DURATION_W-1:0] load;
   logic                  restart;
   logic                  tick;
   logic                  presc_clear;

   always_comb load = (duration_i == '0) ? DURATION_W'(DEFAULT_DURATION) : duration_i;

`ifdef ELEVATOR_DOOR_TIMER_OBSTRUCT_EN
   always_comb restart = (state_q == COUNT) && obstruct_i;
`else
   logic unused_obstruct;
   always_comb unused_obstruct = obstruct_i;
   always_comb restart = 1'b0;
`endif

   // Prescaler only runs while counting; any (re)load or restart realigns it to phase 0.
   always_comb presc_clear = counter_init_i || restart || (state_q != COUNT);

   elevator_tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear_i(presc_clear),
      .tick_o (tick)
   );

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      stored_d    = stored_q;
      if (counter_init_i) begin
         stored_d    = load;
         remaining_d = load;
         state_d     = COUNT;
      end else if (state_q == COUNT) begin
         if (restart) begin
            remaining_d = stored_q;
         end else if (tick) begin
            if (remaining_q == DURATION_W'(1)) begin
               remaining_d = '0;
               state_d     = DONE;
            end else begin
               remaining_d = remaining_q - DURATION_W'(1);
            end
         end
      end
      busy_d = (state_d == COUNT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         stored_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         stored_q    <= stored_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      counter_done_o = done_q;
      busy_o         = busy_q;
      remaining_o    = remaining_q;
   end

endmodule

// File: tb/tb_elevator_door_timer.sv
// Directed bench for elevator_door_timer with an elapsed-time reference model checked every cycle.
module tb_elevator_door_timer;

   localparam int unsigned P  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned DD = 10;
`ifdef ELEVATOR_DOOR_TIMER_OBSTRUCT_EN
   localparam bit OBS_EN = 1'b1;
`else
   localparam bit OBS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init = 1'b0;
   logic [DW-1:0] dur = '0;
   logic          obs = 1'b0;
   logic          done;
   logic          busy;
   logic [DW-1:0] rem;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   elevator_door_timer #(
      .PRESCALE(P),
      .DURATION_W(DW),
      .DEFAULT_DURATION(DD)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .counter_init_i(init),
      .duration_i    (dur),
      .obstruct_i    (obs),
      .counter_done_o(done),
      .busy_o        (busy),
      .remaining_o   (rem)
   );

   // Reference: period start edge and load; remaining = load - elapsed/P, done once elapsed reaches load*P.
   int unsigned e = 0;
   int unsigned m_mode = 0;   // 0 idle, 1 counting, 2 done
   int unsigned m_ref = 0;
   int unsigned m_load = 0;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      e = e + 1;
      if (rst) begin
         m_mode = 0;
         m_load = 0;
      end else if (init) begin
         m_load = (dur == 0) ? DD : int'(dur);
         m_ref  = e;
         m_mode = 1;
      end else if (m_mode == 1 && obs && OBS_EN) begin
         m_ref = e;
      end
      if (m_mode == 1 && (e - m_ref) >= m_load * P) m_mode = 2;
      m_valid = 1'b1;
   end

   function automatic int unsigned exp_rem();
      return (m_mode == 1) ? m_load - (e - m_ref) / P : 0;
   endfunction

   task automatic check(input string name, input int unsigned got, input int unsigned want);
      total = total + 1;
      if (got != want) begin
         bad = bad + 1;
         $display("FAIL %s at edge %0d: got %0d want %0d", name, e, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_busy", busy, (m_mode == 1) ? 1 : 0);
         check("model_done", done, (m_mode == 2) ? 1 : 0);
         check("model_rem", rem, exp_rem());
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_init(input int unsigned d, output int unsigned k);
      init = 1'b1;
      dur  = DW'(d);
      step(1);
      k    = e;
      init = 1'b0;
   endtask

   int unsigned k;
   int unsigned k2;

   initial begin
      step(2);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_rem", rem, 0);
      rst = 1'b0;
      step(3);
      check("idle_done", done, 0);

      // Basic period of 3 ticks
      do_init(3, k);
      check("t1_busy", busy, 1);
      check("t1_rem_k", rem, 3);
      step(3);  check("t1_rem_k3", rem, 3);
      step(1);  check("t1_rem_k4", rem, 2);
      step(4);  check("t1_rem_k8", rem, 1);
      step(3);  check("t1_done_k11", done, 0);
      step(1);  check("t1_done_k12", done, 1);
      check("t1_rem_k12", rem, 0);
      check("t1_busy_k12", busy, 0);
      step(5);  check("t1_done_held", done, 1);

      // Zero duration selects the default
      do_init(0, k);
      check("t2_rem", rem, 10);
      step(39); check("t2_done_k39", done, 0);
      check("t2_rem_k39", rem, 1);
      step(1);  check("t2_done_k40", done, 1);

      // Obstruction at k+5
      do_init(3, k);
      step(4);
      obs = 1'b1;
      step(1);
      obs = 1'b0;
`ifdef ELEVATOR_DOOR_TIMER_OBSTRUCT_EN
      check("t3_rem_k5", rem, 3);
      step(11); check("t3_done_k16", done, 0);
      step(1);  check("t3_done_k17", done, 1);
`else
      check("t4_rem_k5", rem, 2);
      step(6);  check("t4_done_k11", done, 0);
      step(1);  check("t4_done_k12", done, 1);
`endif
      obs = 1'b1;
      step(2);
      obs = 1'b0;
      check("obs_in_done", done, 1);
      check("obs_in_done_rem", rem, 0);

      // Re-init from DONE, then overlapping init at k+6
      do_init(3, k);
      check("t5_done_drops", done, 0);
      check("t5_busy", busy, 1);
      step(5);
      do_init(2, k2);
      check("t5_reinit_rem", rem, 2);
      step(7);  check("t5_done_k13", done, 0);
      step(1);  check("t5_done_k14", done, 1);

      obs = 1'b1;
      do_init(5, k);
      obs = 1'b0;
      check("t5_init_obs_rem", rem, 5);

      // Held init: count starts after the last init edge
      init = 1'b1;
      dur  = 8'd7;
      step(1);
      dur  = 8'd2;
      step(2);
      init = 1'b0;
      check("held_init_rem", rem, 2);
      step(7);  check("held_done_7", done, 0);
      step(1);  check("held_done_8", done, 1);

      // Reset mid-count
      do_init(3, k);
      step(6);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_rem", rem, 0);
      step(20);
      check("t6_no_done", done, 0);
      check("t6_still_idle", busy, 0);

      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
